// File: rtl/c3po_egress_buf.sv
// Per-port store-and-forward egress packet buffer: packets become visible only after their eop beat
// is written, packets that do not fit are dropped whole. Optional macro C3PO_EGRESS_ERR_CNT_EN adds err_cnt.
module c3po_egress_buf #(
  parameter int DATA_W     = 256,
  parameter int DEPTH      = 16,
  parameter int CNT_SIZE_P = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  in_val,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [7:0]            in_vbc,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_val,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [7:0]            out_vbc,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_rdy,
  output logic [AW:0]           level,
  output logic [CNT_SIZE_P-1:0] pkt_out_cnt,
  output logic [CNT_SIZE_P-1:0] pkt_drop_cnt
`ifdef C3PO_EGRESS_ERR_CNT_EN
  ,
  output logic [CNT_SIZE_P-1:0] err_cnt
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DROP} state_e;

  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] PTR_DEPTH = (AW+1)'(DEPTH);

  function automatic logic [CNT_SIZE_P-1:0] sat_add(input logic [CNT_SIZE_P-1:0] cnt,
                                                    input logic [1:0]            inc);
    logic [CNT_SIZE_P:0] sum;
    sum = {1'b0, cnt} + {{(CNT_SIZE_P-1){1'b0}}, inc};
    return sum[CNT_SIZE_P] ? {CNT_SIZE_P{1'b1}} : sum[CNT_SIZE_P-1:0];
  endfunction

  state_e                state_q, state_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           wr_commit_q, wr_commit_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_SIZE_P-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_SIZE_P-1:0] drop_cnt_q, drop_cnt_d;

  logic              mem_sop  [DEPTH];
  logic              mem_eop  [DEPTH];
  logic [7:0]        mem_vbc  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic          full, full_new, start_new, we, err_inc, pop;
  logic [1:0]    drop_inc;
  logic [AW-1:0] waddr, raddr;

  // full uses registered pointers only, so a same-cycle pop never makes room for a write.
  assign full     = (wr_ptr_q - rd_ptr_q) == PTR_DEPTH;
  assign full_new = (wr_commit_q - rd_ptr_q) == PTR_DEPTH;

  always_comb begin
    // NOTE: every signal gets a default before any branch; a missed path would otherwise infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    we          = 1'b0;
    waddr       = wr_ptr_q[AW-1:0];
    drop_inc    = 2'd0;
    err_inc     = 1'b0;
    start_new   = 1'b0;
    if (in_val) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_sop) start_new = 1'b1;
          else        err_inc   = 1'b1;
        end
        ST_PKT: begin
          if (in_sop) begin
            wr_ptr_d  = wr_commit_q;
            drop_inc  = 2'd1;
            err_inc   = 1'b1;
            start_new = 1'b1;
          end else if (full) begin
            wr_ptr_d = wr_commit_q;
            drop_inc = 2'd1;
            state_d  = in_eop ? ST_IDLE : ST_DROP;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (in_eop) begin
              wr_commit_d = wr_ptr_q + PTR_ONE;
              state_d     = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (in_sop) begin
            err_inc   = 1'b1;
            start_new = 1'b1;
          end else if (in_eop) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // A new packet always starts at the commit point, which also covers the rewind case.
      if (start_new) begin
        if (full_new) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = in_eop ? ST_IDLE : ST_DROP;
        end else begin
          we       = 1'b1;
          waddr    = wr_commit_q[AW-1:0];
          wr_ptr_d = wr_commit_q + PTR_ONE;
          if (in_eop) begin
            wr_commit_d = wr_commit_q + PTR_ONE;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_PKT;
          end
        end
      end
    end
  end

  assign raddr = rd_ptr_q[AW-1:0];
  assign pop   = out_val && out_rdy;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = sat_add(drop_cnt_q, drop_inc);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (mem_eop[raddr]) out_cnt_d = sat_add(out_cnt_q, 2'd1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      out_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      out_cnt_q   <= out_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // NOTE: storage has no reset; pointer reset makes every entry invisible and outputs are gated by out_val.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_sop[waddr]  <= in_sop;
      mem_eop[waddr]  <= in_eop;
      mem_vbc[waddr]  <= in_vbc;
      mem_data[waddr] <= in_data;
    end
  end

  assign out_val      = rd_ptr_q != wr_commit_q;
  assign out_sop      = out_val ? mem_sop[raddr]  : 1'b0;
  assign out_eop      = out_val ? mem_eop[raddr]  : 1'b0;
  assign out_vbc      = out_val ? mem_vbc[raddr]  : 8'd0;
  assign out_data     = out_val ? mem_data[raddr] : '0;
  assign level        = wr_commit_q - rd_ptr_q;
  assign pkt_out_cnt  = out_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;

`ifdef C3PO_EGRESS_ERR_CNT_EN
  logic [CNT_SIZE_P-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_inc) err_cnt_d = sat_add(err_cnt_q, 2'd1);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc;
`endif

endmodule

// File: tb/tb_c3po_egress_buf.sv
// Directed self-checking bench for c3po_egress_buf (DEPTH=16); inputs driven and outputs sampled on the falling edge.
module tb_c3po_egress_buf;
  localparam int DATA_W = 256;
  localparam int DEPTH  = 16;
  localparam int CNT    = 8;
  localparam int AW     = $clog2(DEPTH);

  logic              clk     = 1'b0;
  logic              reset_L = 1'b0;
  logic              in_val  = 1'b0;
  logic              in_sop  = 1'b0;
  logic              in_eop  = 1'b0;
  logic [7:0]        in_vbc  = 8'd0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_rdy = 1'b0;
  logic              out_val, out_sop, out_eop;
  logic [7:0]        out_vbc;
  logic [DATA_W-1:0] out_data;
  logic [AW:0]       level;
  logic [CNT-1:0]    pkt_out_cnt, pkt_drop_cnt;
`ifdef C3PO_EGRESS_ERR_CNT_EN
  logic [CNT-1:0]    err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  c3po_egress_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_SIZE_P(CNT)) dut (
    .clk(clk), .reset_L(reset_L),
    .in_val(in_val), .in_sop(in_sop), .in_eop(in_eop), .in_vbc(in_vbc), .in_data(in_data),
    .out_val(out_val), .out_sop(out_sop), .out_eop(out_eop), .out_vbc(out_vbc), .out_data(out_data),
    .out_rdy(out_rdy), .level(level), .pkt_out_cnt(pkt_out_cnt), .pkt_drop_cnt(pkt_drop_cnt)
`ifdef C3PO_EGRESS_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] tag);
    return {(DATA_W/32){tag}};
  endfunction

  task automatic drive(input logic s, input logic e, input logic [7:0] v, input logic [31:0] tag);
    in_val  = 1'b1;
    in_sop  = s;
    in_eop  = e;
    in_vbc  = v;
    in_data = mk_data(tag);
  endtask

  task automatic idle_in();
    in_val  = 1'b0;
    in_sop  = 1'b0;
    in_eop  = 1'b0;
    in_vbc  = 8'd0;
    in_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    out_rdy = 1'b0;
    reset_L = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    idle_in();
    reset_L = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL reset_out_val: got %0b want 0", out_val); end
    checks++; if (level !== '0) begin failures++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (pkt_out_cnt !== '0 || pkt_drop_cnt !== '0) begin failures++;
      $display("FAIL reset_counters: got out=%0d drop=%0d want 0/0", pkt_out_cnt, pkt_drop_cnt); end
    checks++; if (out_data !== '0 || out_vbc !== 8'd0 || out_sop !== 1'b0 || out_eop !== 1'b0) begin failures++;
      $display("FAIL reset_out_fields: got vbc=%0d sop=%0b eop=%0b want zeros", out_vbc, out_sop, out_eop); end
    reset_L = 1'b1;
  endtask

  task automatic test_single_pkt();
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL t1_early_val beat %0d: got 1 want 0", i); end
      drive(i == 0, i == 3, (i == 3) ? 8'd5 : 8'd32, 32'h100 + i);
    end
    @(negedge clk);
    idle_in();
    checks++; if (level !== 5'd4) begin failures++; $display("FAIL t1_level: got %0d want 4", level); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (out_val !== 1'b1 || out_sop !== (k == 0) || out_eop !== (k == 3) ||
          out_vbc !== ((k == 3) ? 8'd5 : 8'd32) || out_data !== mk_data(32'h100 + k)) begin
        failures++;
        $display("FAIL t1_beat%0d: got val=%0b sop=%0b eop=%0b vbc=%0d tag=%0h want val=1 tag=%0h",
                 k, out_val, out_sop, out_eop, out_vbc, out_data[31:0], 32'h100 + k);
      end
    end
    @(negedge clk);
    checks++; if (out_val !== 1'b0 || level !== '0) begin failures++;
      $display("FAIL t1_drained: got val=%0b level=%0d want 0/0", out_val, level); end
    checks++; if (pkt_out_cnt !== 8'd1) begin failures++; $display("FAIL t1_out_cnt: got %0d want 1", pkt_out_cnt); end
  endtask

  task automatic test_full_drop();
    do_reset();
    out_rdy = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 6; b++) begin
        @(negedge clk);
        drive(b == 0, b == 5, (b == 5) ? 8'd9 : 8'd32, 32'h200 + p * 16 + b);
      end
    end
    @(negedge clk);
    idle_in();
    checks++; if (level !== 5'd12) begin failures++; $display("FAIL t2_level: got %0d want 12", level); end
    checks++; if (pkt_drop_cnt !== 8'd1) begin failures++; $display("FAIL t2_drop: got %0d want 1", pkt_drop_cnt); end
    checks++; if (pkt_out_cnt !== 8'd0) begin failures++; $display("FAIL t2_out_cnt_stalled: got %0d want 0", pkt_out_cnt); end
    out_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (out_val !== 1'b1 || out_eop !== (i % 6 == 5) || out_data !== mk_data(32'h200 + (i / 6) * 16 + (i % 6))) begin
        failures++;
        $display("FAIL t2_beat%0d: got val=%0b eop=%0b tag=%0h want tag=%0h", i, out_val, out_eop,
                 out_data[31:0], 32'h200 + (i / 6) * 16 + (i % 6));
      end
    end
    @(negedge clk);
    checks++; if (out_val !== 1'b0 || level !== '0) begin failures++;
      $display("FAIL t2_drained: got val=%0b level=%0d want 0/0", out_val, level); end
    checks++; if (pkt_out_cnt !== 8'd2) begin failures++; $display("FAIL t2_out_cnt: got %0d want 2", pkt_out_cnt); end
  endtask

  task automatic test_back_to_back();
    int                idx = 0;
    logic              prev_stall = 1'b0;
    logic [7:0]        prev_vbc   = 8'd0;
    logic [DATA_W-1:0] prev_data  = '0;
    do_reset();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (out_val !== 1'b1 || out_vbc !== prev_vbc || out_data !== prev_data) begin
          failures++;
          $display("FAIL t3_stall_hold cyc %0d: got val=%0b vbc=%0d want val=1 vbc=%0d", c, out_val, out_vbc, prev_vbc);
        end
      end
      out_rdy = (c % 2 == 0);
      if (out_val && out_rdy) begin
        checks++;
        if (out_data !== mk_data(32'h300 + idx) || out_vbc !== 8'(idx + 1)) begin
          failures++;
          $display("FAIL t3_pkt%0d: got tag=%0h vbc=%0d want tag=%0h vbc=%0d", idx, out_data[31:0], out_vbc,
                   32'h300 + idx, idx + 1);
        end
        idx++;
      end
      prev_stall = out_val && !out_rdy;
      prev_vbc   = out_vbc;
      prev_data  = out_data;
      if (c < 20) drive(1'b1, 1'b1, 8'(c + 1), 32'h300 + c);
      else        idle_in();
      if (idx == 20) break;
    end
    checks++; if (idx != 20) begin failures++; $display("FAIL t3_timeout: got %0d pkts want 20", idx); end
    @(negedge clk);
    idle_in();
    out_rdy = 1'b0;
    checks++; if (pkt_out_cnt !== 8'd20 || pkt_drop_cnt !== 8'd0) begin failures++;
      $display("FAIL t3_counts: got out=%0d drop=%0d want 20/0", pkt_out_cnt, pkt_drop_cnt); end
    checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL t3_drained: got 1 want 0"); end
  endtask

  task automatic test_sop_rewind();
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(i == 0, 1'b0, 8'd32, 32'h400 + i);
    end
    @(negedge clk);
    checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL t4_partial_visible: got 1 want 0"); end
    drive(1'b1, 1'b1, 8'd7, 32'h4AA);
    @(negedge clk);
    idle_in();
    checks++; if (pkt_drop_cnt !== 8'd1) begin failures++; $display("FAIL t4_drop: got %0d want 1", pkt_drop_cnt); end
    checks++;
    if (out_val !== 1'b1 || out_sop !== 1'b1 || out_eop !== 1'b1 || out_vbc !== 8'd7 || out_data !== mk_data(32'h4AA)) begin
      failures++;
      $display("FAIL t4_new_pkt: got val=%0b sop=%0b eop=%0b vbc=%0d tag=%0h want 1/1/1/7/4aa",
               out_val, out_sop, out_eop, out_vbc, out_data[31:0]);
    end
    @(negedge clk);
    checks++; if (pkt_out_cnt !== 8'd1 || level !== '0) begin failures++;
      $display("FAIL t4_done: got out=%0d level=%0d want 1/0", pkt_out_cnt, level); end
`ifdef C3PO_EGRESS_ERR_CNT_EN
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL t4_err: got %0d want 1", err_cnt); end
`endif
  endtask

  task automatic test_no_sop();
    do_reset();
    out_rdy = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd12, 32'h500);
    @(negedge clk);
    idle_in();
    checks++; if (out_val !== 1'b0 || level !== '0) begin failures++;
      $display("FAIL t5_discard: got val=%0b level=%0d want 0/0", out_val, level); end
    @(negedge clk);
    checks++; if (pkt_out_cnt !== 8'd0 || pkt_drop_cnt !== 8'd0) begin failures++;
      $display("FAIL t5_counts: got out=%0d drop=%0d want 0/0", pkt_out_cnt, pkt_drop_cnt); end
`ifdef C3PO_EGRESS_ERR_CNT_EN
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL t5_err: got %0d want 1", err_cnt); end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    out_rdy = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 8'd4, 32'h5F0);
    @(negedge clk);
    idle_in();
    @(negedge clk);
    out_rdy = 1'b0;
    drive(1'b1, 1'b0, 8'd32, 32'h5E0);
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        drive(b == 0, b == 3, 8'd32, 32'h600 + p * 16 + b);
      end
    end
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      drive(b == 0, 1'b0, 8'd32, 32'h680 + b);
    end
    @(negedge clk);
    idle_in();
    checks++; if (level !== 5'd8 || pkt_out_cnt !== 8'd1 || pkt_drop_cnt !== 8'd1) begin failures++;
      $display("FAIL t6_pre: got level=%0d out=%0d drop=%0d want 8/1/1", level, pkt_out_cnt, pkt_drop_cnt); end
    #2 reset_L = 1'b0;
    #1;
    checks++; if (out_val !== 1'b0 || level !== '0) begin failures++;
      $display("FAIL t6_async: got val=%0b level=%0d want 0/0", out_val, level); end
    checks++; if (pkt_out_cnt !== '0 || pkt_drop_cnt !== '0) begin failures++;
      $display("FAIL t6_counters: got out=%0d drop=%0d want 0/0", pkt_out_cnt, pkt_drop_cnt); end
    @(negedge clk);
    reset_L = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 8'd3, 32'h6AA);
    @(negedge clk);
    idle_in();
    checks++; if (out_val !== 1'b1 || out_vbc !== 8'd3 || out_data !== mk_data(32'h6AA)) begin failures++;
      $display("FAIL t6_post_pkt: got val=%0b vbc=%0d tag=%0h want 1/3/6aa", out_val, out_vbc, out_data[31:0]); end
    @(negedge clk);
    checks++; if (pkt_out_cnt !== 8'd1 || out_val !== 1'b0) begin failures++;
      $display("FAIL t6_post_cnt: got out=%0d val=%0b want 1/0", pkt_out_cnt, out_val); end
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_full_drop();
    test_back_to_back();
    test_sop_rewind();
    test_no_sop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
